// File: rtl/md_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : md_unit_pkg
// Purpose : Shared definitions for the multiply/divide unit: 3-bit md op
//           codes, FSM state encoding and op-class decode helpers that
//           Control/Stall logic can reuse.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package md_unit_pkg;

  // Codes 0 and 7 are not md operations and are ignored by md_unit.
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // True for ops that occupy the unit for a multi-cycle latency.
  function automatic logic md_is_muldiv(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_mul(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  // Any op the stall unit treats as an md instruction.
  function automatic logic md_is_md_op(input logic [2:0] op);
    return md_is_muldiv(op) || (op == MD_MTHI) || (op == MD_MTLO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_core.sv
`default_nettype none
// ============================================================================
// Module  : md_core
// Purpose : Combinational signed/unsigned multiply and divide datapath.
//           Produces the HI/LO values an op would commit plus a divide-by-
//           zero flag. Can be replaced by an iterative divider honouring the
//           same latency contract in md_unit.
// Ports   : op_i   [2:0]     md op code
//           a_i    [WIDTH]   rs operand (multiplicand / dividend)
//           b_i    [WIDTH]   rt operand (multiplier / divisor)
//           hi_o   [WIDTH]   product high half or remainder
//           lo_o   [WIDTH]   product low half or quotient
//           dz_o             divide op with zero divisor
// Revision: 1.0 - initial release
// ============================================================================
module md_core
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             dz_o
);

  localparam logic [WIDTH-1:0] C_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] C_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic signed [2*WIDTH-1:0] w_prod_s;
  logic        [2*WIDTH-1:0] w_prod_u;
  logic        [WIDTH-1:0]   w_div_b;
  logic        [WIDTH-1:0]   w_q_s, w_r_s, w_q_u, w_r_u;
  logic                      w_b_zero, w_ovf;

  // Operands are extended to 2*WIDTH so the full product is kept.
  assign w_prod_s = $signed({{WIDTH{a_i[WIDTH-1]}}, a_i}) *
                    $signed({{WIDTH{b_i[WIDTH-1]}}, b_i});
  assign w_prod_u = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

  // A zero divisor is replaced by one so the divider never sees x/0;
  // the result is discarded anyway via dz_o.
  assign w_b_zero = (b_i == '0);
  assign w_div_b  = w_b_zero ? C_ONE : b_i;
  assign w_ovf    = (a_i == C_MIN) && (b_i == C_ONES);

  // SystemVerilog signed / and % truncate toward zero, remainder follows
  // the dividend's sign, which is exactly the required DIV semantics.
  assign w_q_s = $signed(a_i) / $signed(w_div_b);
  assign w_r_s = $signed(a_i) % $signed(w_div_b);
  assign w_q_u = a_i / w_div_b;
  assign w_r_u = a_i % w_div_b;

  always_comb begin
    hi_o = '0;
    lo_o = '0;
    dz_o = 1'b0;
    case (op_i)
      MD_MULT: begin
        hi_o = w_prod_s[2*WIDTH-1:WIDTH];
        lo_o = w_prod_s[WIDTH-1:0];
      end
      MD_MULTU: begin
        hi_o = w_prod_u[2*WIDTH-1:WIDTH];
        lo_o = w_prod_u[WIDTH-1:0];
      end
      MD_DIV: begin
        dz_o = w_b_zero;
        if (w_ovf) begin
          lo_o = C_MIN;
          hi_o = '0;
        end else begin
          lo_o = w_q_s;
          hi_o = w_r_s;
        end
      end
      MD_DIVU: begin
        dz_o = w_b_zero;
        lo_o = w_q_u;
        hi_o = w_r_u;
      end
      default: begin
        hi_o = '0;
        lo_o = '0;
        dz_o = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module  : md_unit
// Purpose : Multi-cycle multiply/divide unit with HI/LO registers for the EX
//           stage. A mult/div result is computed at acceptance, held for a
//           fixed latency while busy is high, then committed to HI/LO.
//           MTHI/MTLO write HI/LO directly in a single cycle.
// Ports   : clk            rising-edge clock
//           reset          asynchronous active-low reset
//           start          md instruction valid this cycle
//           op     [2:0]   md op code (md_unit_pkg::MD_*)
//           a      [WIDTH] rs operand
//           b      [WIDTH] rt operand (unused by MTHI/MTLO)
//           cancel         abort in-flight op / suppress start
//           busy           mult/div in flight (registered)
//           hi     [WIDTH] HI register
//           lo     [WIDTH] LO register
// Revision: 1.0 - initial release
// ============================================================================
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_LAT + 1);

  localparam logic [CW-1:0] C_MUL_LAT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] C_DIV_LAT = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] C_CNT_ONE = CW'(1);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
  logic             pend_dz_q, pend_dz_d;

  logic [WIDTH-1:0] core_hi, core_lo;
  logic             core_dz;

  md_core #(.WIDTH(WIDTH)) u_core (
    .op_i (op),
    .a_i  (a),
    .b_i  (b),
    .hi_o (core_hi),
    .lo_o (core_lo),
    .dz_o (core_dz)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_dz_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;

    case (state_q)
      ST_IDLE: begin
        // cancel also suppresses a same-cycle start, MTHI/MTLO included.
        if (start && !cancel) begin
          if (md_is_muldiv(op)) begin
            // Operands are captured only here; later a/b changes are ignored.
            pend_hi_d = core_hi;
            pend_lo_d = core_lo;
            pend_dz_d = core_dz;
            cnt_d     = md_is_mul(op) ? C_MUL_LAT : C_DIV_LAT;
            busy_d    = 1'b1;
            state_d   = ST_RUN;
          end else if (op == MD_MTHI) begin
            hi_d = a;
          end else if (op == MD_MTLO) begin
            lo_d = a;
          end
        end
      end

      ST_RUN: begin
        // start is ignored while running; cancel wins over a same-edge commit.
        if (cancel) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q == C_CNT_ONE) begin
          if (!pend_dz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - C_CNT_ONE;
        end
      end

      default: begin
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_md_unit
// Purpose : Self-checking bench for md_unit (WIDTH=32, MULT=5, DIV=10).
//           Stimulus pushes expected HI/LO and busy length into a queue; a
//           monitor pops and compares each time busy falls.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_md_unit;
  import md_unit_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;   // 0 = busy length not checked
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cancel = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  int   bcnt = 0;
  logic prev_busy = 1'b0;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: counts busy cycles, compares when busy falls.
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) begin
      bcnt++;
    end else if (prev_busy === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_busy_drop: got busy-fall expected none");
      end else begin
        e = sb_q.pop_front();
        chk({e.name, "_hi"}, hi, e.hi);
        chk({e.name, "_lo"}, lo, e.lo);
        if (e.lat != 0) chk({e.name, "_busylen"}, 32'(bcnt), 32'(e.lat));
      end
      bcnt = 0;
    end
    prev_busy = busy;
  end

  task automatic push(input string nm, input logic [31:0] eh, input logic [31:0] el, input int lat);
    exp_t e;
    e.name = nm; e.hi = eh; e.lo = el; e.lat = lat;
    sb_q.push_back(e);
  endtask

  // Drive one start cycle, then scramble operands to prove they are sampled once.
  task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'd0; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
  endtask

  task automatic wait_idle(input string nm);
    bit done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got busy=1 expected busy=0 within 40 cycles", nm);
    end
  endtask

  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] eh, input logic [31:0] el,
                        input int lat);
    push(nm, eh, el, lat);
    issue(o, va, vb);
    wait_idle(nm);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // 1-2: multiplies
    run_op("mult_m3x5",   MD_MULT,  32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5);
    run_op("multu_ffx2",  MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5);
    run_op("mult_m1x2",   MD_MULT,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
    // 3: divides
    run_op("div_m7d2",    MD_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    run_op("div_7dm2",    MD_DIV,   32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10);
    run_op("div_ovf",     MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10);
    run_op("divu_7d2",    MD_DIVU,  32'd7, 32'd2, 32'h1, 32'h3, 10);

    // 4: MTHI then divide by zero leaves HI/LO untouched
    issue(MD_MTHI, 32'h1234, 32'h0);
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_lo", lo, 32'h3);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    run_op("divu_dz",     MD_DIVU,  32'd7, 32'd0, 32'h1234, 32'h3, 10);

    // MTLO, then MTLO with cancel in the same cycle is suppressed
    issue(MD_MTLO, 32'hABCD, 32'h0);
    chk("mtlo_lo", lo, 32'hABCD);
    @(negedge clk);
    start = 1'b1; op = MD_MTLO; a = 32'h5555; cancel = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; cancel = 1'b0;
    chk("mtlo_cancel_lo", lo, 32'hABCD);
    chk("mtlo_cancel_busy", {31'd0, busy}, 32'd0);

    // 5: cancel at cycle 3
    push("mult_cancel3", 32'h1234, 32'hABCD, 3);
    issue(MD_MULT, 32'd6, 32'd7);
    repeat (2) @(negedge clk);
    @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    wait_idle("mult_cancel3");

    // cancel on the commit edge
    push("mult_cancel5", 32'h1234, 32'hABCD, 5);
    issue(MD_MULT, 32'd6, 32'd7);
    repeat (4) @(negedge clk);
    @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    wait_idle("mult_cancel5");

    run_op("mult_6x7",    MD_MULT,  32'd6, 32'd7, 32'h0, 32'h2A, 5);

    // 6: start while busy is ignored
    push("divu_busy_start", 32'h1, 32'h3, 10);
    issue(MD_DIVU, 32'd7, 32'd2);
    @(negedge clk);
    start = 1'b1; op = MD_MULTU; a = 32'd100; b = 32'd100;
    @(negedge clk);
    start = 1'b1; op = MD_MTHI; a = 32'h7777;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'd0;
    wait_idle("divu_busy_start");
    repeat (3) @(negedge clk);
    chk("after_ignored_busy", {31'd0, busy}, 32'd0);
    chk("after_ignored_hi", hi, 32'h1);

    // reset pulsed mid-DIV
    push("div_reset", 32'h0, 32'h0, 0);
    issue(MD_DIV, 32'd100, 32'd3);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_hi", hi, 32'd0);
    chk("midreset_lo", lo, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("postreset_busy", {31'd0, busy}, 32'd0);
    chk("postreset_lo", lo, 32'd0);

    repeat (2) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
